// File: rtl/array_mult_if.sv
// Requester/responder bundle for the shared lane multiplier: per-lane operand
// pairs in, rescaled products plus valid and per-lane saturation flags out.
interface array_mult_if #(
   parameter int LANES = 6,
   parameter int WIDTH = 27
);
   logic                         en;
   logic                         in_valid;
   logic [LANES-1:0][WIDTH-1:0]  array_mult_dataa;
   logic [LANES-1:0][WIDTH-1:0]  array_mult_datab;
   logic [LANES-1:0][WIDTH-1:0]  array_mult_result;
   logic                         out_valid;
   logic [LANES-1:0]             sat_flag;

   modport master (
      output en, in_valid, array_mult_dataa, array_mult_datab,
      input  array_mult_result, out_valid, sat_flag
   );

   modport slave (
      input  en, in_valid, array_mult_dataa, array_mult_datab,
      output array_mult_result, out_valid, sat_flag
   );
endinterface

// File: rtl/array_mult.sv
// Multi-lane signed Q-format multiplier: 4-stage pipeline (register, multiply,
// round/shift, saturate) with global advance enable and no backpressure.
module array_mult #(
   parameter int LANES = 6,
   parameter int WIDTH = 27,
   parameter int FRAC  = 8
) (
   input  logic         clk,
   input  logic         rst,
   array_mult_if.slave  bus
);
   localparam int PW = 2 * WIDTH;
   localparam logic signed [PW-1:0] RND  = PW'(1) << (FRAC - 1);
   localparam logic signed [PW-1:0] MAXV = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] MINV = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   // Round half toward +infinity, then drop the fractional bits.
   function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] sum;
      sum = p + RND;
      return sum >>> FRAC;
   endfunction

   // Returns {sat, value}; clamps anything outside the WIDTH-bit signed range.
   function automatic logic [WIDTH:0] saturate(input logic signed [PW-1:0] v);
      if (v > MAXV)      return {1'b1, MAXV[WIDTH-1:0]};
      else if (v < MINV) return {1'b1, MINV[WIDTH-1:0]};
      else               return {1'b0, v[WIDTH-1:0]};
   endfunction

   logic signed [WIDTH-1:0] a_p1_q    [LANES];
   logic signed [WIDTH-1:0] a_p1_d    [LANES];
   logic signed [WIDTH-1:0] b_p1_q    [LANES];
   logic signed [WIDTH-1:0] b_p1_d    [LANES];
   logic                    vld_p1_q, vld_p1_d;
   logic signed [PW-1:0]    prod_p2_q [LANES];
   logic signed [PW-1:0]    prod_p2_d [LANES];
   logic                    vld_p2_q, vld_p2_d;
   logic signed [PW-1:0]    shf_p3_q  [LANES];
   logic signed [PW-1:0]    shf_p3_d  [LANES];
   logic                    vld_p3_q, vld_p3_d;
   logic signed [WIDTH-1:0] res_p4_q  [LANES];
   logic signed [WIDTH-1:0] res_p4_d  [LANES];
   logic [LANES-1:0]        sat_p4_q, sat_p4_d;
   logic                    vld_p4_q, vld_p4_d;

   always_comb begin
      vld_p1_d = bus.in_valid;
      vld_p2_d = vld_p1_q;
      vld_p3_d = vld_p2_q;
      vld_p4_d = vld_p3_q;
      sat_p4_d = '0;
      for (int i = 0; i < LANES; i++) begin
         // S1: capture operands
         a_p1_d[i] = $signed(bus.array_mult_dataa[i]);
         b_p1_d[i] = $signed(bus.array_mult_datab[i]);
         // S2: full-width product; MIN*MIN still fits in 2*WIDTH bits
         prod_p2_d[i] = PW'(a_p1_q[i]) * PW'(b_p1_q[i]);
         // S3: rescale
         shf_p3_d[i] = round_shift(prod_p2_q[i]);
         // S4: clamp to output width
         {sat_p4_d[i], res_p4_d[i]} = saturate(shf_p3_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_p1_q    <= '{default: '0};
         b_p1_q    <= '{default: '0};
         prod_p2_q <= '{default: '0};
         shf_p3_q  <= '{default: '0};
         res_p4_q  <= '{default: '0};
         sat_p4_q  <= '0;
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         vld_p3_q  <= 1'b0;
         vld_p4_q  <= 1'b0;
      end else if (bus.en) begin
         a_p1_q    <= a_p1_d;
         b_p1_q    <= b_p1_d;
         prod_p2_q <= prod_p2_d;
         shf_p3_q  <= shf_p3_d;
         res_p4_q  <= res_p4_d;
         sat_p4_q  <= sat_p4_d;
         vld_p1_q  <= vld_p1_d;
         vld_p2_q  <= vld_p2_d;
         vld_p3_q  <= vld_p3_d;
         vld_p4_q  <= vld_p4_d;
      end
   end

   always_comb begin
      bus.array_mult_result = '0;
      for (int i = 0; i < LANES; i++) begin
         bus.array_mult_result[i] = res_p4_q[i];
      end
   end

   assign bus.out_valid = vld_p4_q;
   assign bus.sat_flag  = sat_p4_q;
endmodule

// File: tb/tb_array_mult.sv
// Directed plus randomized bench for array_mult with an arithmetic reference
// model and a 3-entry delay queue that tracks enabled edges and resets.
module tb_array_mult;
   localparam int    LANES = 6;
   localparam int    WIDTH = 27;
   localparam int    FRAC  = 8;
   localparam longint MAXL = 67108863;
   localparam longint MINL = -67108864;

   typedef struct packed {
      logic [LANES-1:0][WIDTH-1:0] res;
      logic [LANES-1:0]            sat;
      logic                        vld;
   } rec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   array_mult_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

   array_mult #(.LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   rec_t pipe_q[$];
   rec_t exp_r;
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [WIDTH-1:0] w(input longint v);
      return v[WIDTH-1:0];
   endfunction

   // Reference: exact product, floor((p + half) / 2^FRAC), clamp to range.
   function automatic rec_t model_req(input logic [LANES-1:0][WIDTH-1:0] a,
                                      input logic [LANES-1:0][WIDTH-1:0] b,
                                      input logic v);
      rec_t   r;
      longint p, q;
      r = '0;
      r.vld = v;
      for (int i = 0; i < LANES; i++) begin
         p = longint'($signed(a[i])) * longint'($signed(b[i]));
         q = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
         if (q > MAXL) begin
            r.res[i] = w(MAXL);
            r.sat[i] = 1'b1;
         end else if (q < MINL) begin
            r.res[i] = w(MINL);
            r.sat[i] = 1'b1;
         end else begin
            r.res[i] = q[WIDTH-1:0];
         end
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock: update the model from what is driven, then compare.
   task automatic tick();
      if (rst) begin
         exp_r = '0;
         pipe_q.delete();
         repeat (3) pipe_q.push_back(rec_t'(0));
      end else if (bus.en) begin
         pipe_q.push_back(model_req(bus.array_mult_dataa, bus.array_mult_datab, bus.in_valid));
         exp_r = pipe_q.pop_front();
      end
      @(posedge clk);
      #1;
      check("model_result", bus.array_mult_result, exp_r.res);
      check("model_sat", bus.sat_flag, exp_r.sat);
      check("model_valid", bus.out_valid, exp_r.vld);
   endtask

   task automatic clear_ops();
      bus.array_mult_dataa = '0;
      bus.array_mult_datab = '0;
      bus.in_valid = 1'b0;
   endtask

   task automatic set_lane(input int i, input longint a, input longint b);
      bus.array_mult_dataa[i] = w(a);
      bus.array_mult_datab[i] = w(b);
   endtask

   function automatic longint rand_op();
      logic [31:0] r;
      int          mode;
      r = $urandom();
      mode = $urandom_range(0, 3);
      case (mode)
         0: return longint'($signed(r[12:0]));
         1: return longint'($signed(r[WIDTH-1:0]));
         2: case (r[1:0])
               2'd0: return MAXL;
               2'd1: return MINL;
               2'd2: return 0;
               default: return -1;
            endcase
         default: return longint'($signed(r[18:0]));
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      bus.en = 1'b0;
      clear_ops();

      // Reset held 3 cycles
      repeat (3) tick();
      check("rst_result", bus.array_mult_result, '0);
      check("rst_valid", bus.out_valid, 1'b0);
      check("rst_sat", bus.sat_flag, '0);
      rst = 1'b0;
      bus.en = 1'b1;

      // Latency: request in cycle 0, visible only in cycle 4
      set_lane(0, 256, 256);
      bus.in_valid = 1'b1;
      tick();
      clear_ops();
      check("lat_vld_c1", bus.out_valid, 1'b0);
      tick();
      check("lat_vld_c2", bus.out_valid, 1'b0);
      tick();
      check("lat_vld_c3", bus.out_valid, 1'b0);
      tick();
      check("lat_vld_c4", bus.out_valid, 1'b1);
      check("lat_res_c4", bus.array_mult_result[0], w(256));
      check("lat_sat_c4", bus.sat_flag, '0);
      tick();
      check("lat_vld_c5", bus.out_valid, 1'b0);

      // Signed operands and rounding
      set_lane(0, -256, 128);
      set_lane(1, 1, 128);
      set_lane(2, -1, 128);
      set_lane(3, 3, 85);
      bus.in_valid = 1'b1;
      tick();
      clear_ops();
      repeat (3) tick();
      check("rnd_neg", bus.array_mult_result[0], w(-128));
      check("rnd_half_up", bus.array_mult_result[1], w(1));
      check("rnd_neg_half", bus.array_mult_result[2], w(0));
      check("rnd_3x85", bus.array_mult_result[3], w(1));
      check("rnd_sat", bus.sat_flag, '0);

      // Saturation, with an unaffected neighbour lane
      set_lane(0, MAXL, MAXL);
      set_lane(1, MINL, MAXL);
      set_lane(2, MINL, MINL);
      set_lane(3, 256, 512);
      bus.in_valid = 1'b1;
      tick();
      clear_ops();
      repeat (3) tick();
      check("sat_pos", bus.array_mult_result[0], w(MAXL));
      check("sat_neg", bus.array_mult_result[1], w(MINL));
      check("sat_minmin", bus.array_mult_result[2], w(MAXL));
      check("sat_neigh", bus.array_mult_result[3], w(512));
      check("sat_flags", bus.sat_flag, 6'b000111);
      check("sat_vld", bus.out_valid, 1'b1);

      // Back-to-back streaming of 6 requests
      for (int t = 0; t < 10; t++) begin
         clear_ops();
         if (t < 6) begin
            set_lane(0, (t + 1) * 256, 256);
            bus.in_valid = 1'b1;
         end
         tick();
         if (t >= 3 && t < 9) begin
            check("stream_vld", bus.out_valid, 1'b1);
            check("stream_res", bus.array_mult_result[0], w((t - 2) * 256));
         end
      end
      check("stream_end_vld", bus.out_valid, 1'b0);

      // Stall: en low for 5 cycles after the 2nd enabled edge
      set_lane(0, 512, 256);
      bus.in_valid = 1'b1;
      tick();
      clear_ops();
      tick();
      bus.en = 1'b0;
      set_lane(0, 1000, 1000);
      bus.in_valid = 1'b1;
      repeat (5) begin
         tick();
         check("stall_vld", bus.out_valid, 1'b0);
      end
      bus.en = 1'b1;
      clear_ops();
      tick();
      check("stall_e3_vld", bus.out_valid, 1'b0);
      tick();
      check("stall_e4_vld", bus.out_valid, 1'b1);
      check("stall_e4_res", bus.array_mult_result[0], w(512));
      tick();

      // Reset mid-flight discards everything in the pipe
      set_lane(0, 256, 256);
      bus.in_valid = 1'b1;
      tick();
      set_lane(0, 512, 256);
      tick();
      set_lane(0, 1024, 256);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_ops();
      repeat (5) begin
         tick();
         check("rstmid_vld", bus.out_valid, 1'b0);
      end
      set_lane(0, 768, 256);
      bus.in_valid = 1'b1;
      tick();
      clear_ops();
      repeat (3) tick();
      check("rstmid_next_vld", bus.out_valid, 1'b1);
      check("rstmid_next_res", bus.array_mult_result[0], w(768));

      // Randomized traffic with random stalls and occasional reset
      for (int n = 0; n < 400; n++) begin
         bus.en = ($urandom_range(0, 7) != 0);
         rst = ($urandom_range(0, 99) == 0);
         bus.in_valid = $urandom_range(0, 1);
         for (int i = 0; i < LANES; i++) set_lane(i, rand_op(), rand_op());
         tick();
      end
      rst = 1'b0;
      bus.en = 1'b1;
      clear_ops();
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/array_mult.md
Name: array_mult

Overview:
- Shared multi-lane signed fixed-point multiplier that services the matrix-building blocks (t_block and successors).
- Requesters drive per-lane operand pairs; the block returns per-lane products, rescaled to the same Q-format, after a fixed pipeline latency.
- It is the responder end of the array_mult_dataa / array_mult_datab / array_mult_result interface.
- Number format: 27-bit two's complement, 8 fractional bits, so 256 represents 1.0.

Parameters:
- LANES, 6, number of independent multiplier lanes.
- WIDTH, 27, operand and result width in bits (signed).
- FRAC, 8, fractional bits; product is rescaled by 2^-FRAC.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance enable; low freezes every stage.
- in_valid  in  1  operands on dataa/datab are a request this cycle.
- array_mult_dataa  in  LANES x WIDTH  signed operand A per lane.
- array_mult_datab  in  LANES x WIDTH  signed operand B per lane.
- array_mult_result  out  LANES x WIDTH  rescaled, rounded, saturated product per lane.
- out_valid  out  1  array_mult_result holds the response to an in_valid request.
- sat_flag  out  LANES  per-lane flag, qualified by out_valid: that lane saturated.

Behaviour:
- Reset (rst high at a clk edge):
  - All pipeline registers, array_mult_result, out_valid and sat_flag are cleared to 0 on that edge.
  - rst has priority over en.
  - Reset mid-operation discards all in-flight requests; no out_valid is produced for them.
- Pipeline: 4 stages, latency exactly 4 enabled cycles.
  - S1: register dataa, datab, in_valid.
  - S2: full signed product, 2*WIDTH bits.
  - S3: add the rounding constant 2^(FRAC-1), then arithmetic shift right by FRAC (round half toward +infinity).
  - S4: saturate to WIDTH bits, register result, sat_flag and out_valid.
- A request sampled at enabled edge N appears on the outputs after enabled edge N+3, i.e. visible during cycle N+4 when en is continuously high.
- Throughput: one request per enabled cycle. No backpressure and no ready signal; requesters schedule against the fixed latency.
- en low:
  - No stage updates.
  - Outputs, including out_valid, hold their values.
  - Inputs are ignored that cycle.
  - Latency is counted in enabled cycles only.
- in_valid low:
  - Operands still flow through the pipeline; only the valid bit is cleared.
  - Result data is don't-care when out_valid is 0, but the bench shall see deterministic products of the inputs given.
- Saturation, with MAX = 2^(WIDTH-1)-1 and MIN = -2^(WIDTH-1):
  - A shifted value above MAX outputs MAX and sets sat_flag for that lane.
  - A shifted value below MIN outputs MIN and sets sat_flag for that lane.
  - Otherwise the low WIDTH bits are output and sat_flag is 0.
- Lanes are fully independent; one lane saturating does not affect the others.
- Zero operands produce exactly 0 with no rounding artefact, since (0 + 128) >> 8 = 0.
- The MIN x MIN product must not overflow the 2*WIDTH-bit intermediate; it saturates to MAX.

Test Plan:
- Reset and latency: hold rst 3 cycles, then en=1; lane0 256 x 256 with in_valid pulsed at cycle 0 -> out_valid high only in cycle 4, result[0] = 256, sat_flag = 0; all outputs 0 during and right after reset.
- Signed and rounding on lanes 0-3:
  - -256 x 128 -> -128.
  - 1 x 128 -> 1 (half rounds up).
  - -1 x 128 -> 0.
  - 3 x 85 -> 1 (255 + 128 = 383, >> 8 = 1).
- Saturation:
  - 67108863 x 67108863 -> 67108863, sat_flag = 1.
  - -67108864 x 67108863 -> -67108864, sat_flag = 1.
  - -67108864 x -67108864 -> 67108863, sat_flag = 1.
  - Neighbouring lane 256 x 512 -> 512 with its flag 0.
- Back-to-back streaming: 6 consecutive valid requests (lane0 = k*256 x 256 for k = 1..6) -> results 256, 512, ..., 1536 on 6 consecutive cycles starting 4 cycles after the first request.
- Stall: issue a request, drop en for 5 cycles after the 2nd edge -> outputs and out_valid frozen during the stall; result appears after 4 total enabled edges with the correct value.
- Reset mid-flight: issue 3 valid requests, assert rst for 1 cycle after the second -> no out_valid for any of them; the next request after reset returns normally at latency 4.
